// File: rtl/fetch_pkg.sv
// Shared constants and helpers for the decoupled instruction fetch unit.
package fetch_pkg;

  localparam int          XLEN_DEFAULT     = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0020;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;

  // Redirect target priority: taken branch beats jump; jump_reg picks the
  // register target only for a jump.
  function automatic logic [XLEN_DEFAULT-1:0] select_target(
    input logic                    branch,
    input logic                    jump_reg,
    input logic [XLEN_DEFAULT-1:0] branch_addr,
    input logic [XLEN_DEFAULT-1:0] jump_reg_addr,
    input logic [XLEN_DEFAULT-1:0] jump_addr
  );
    return branch ? branch_addr : (jump_reg ? jump_reg_addr : jump_addr);
  endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Redirect, instruction-memory and decode-side signals of the fetch unit.
interface fetch_queue_if #(
  parameter int XLEN = 32
);
  // redirect inputs from PC-select logic
  logic            jump;
  logic            jump_reg;
  logic            branch;
  logic [XLEN-1:0] branch_addr;
  logic [XLEN-1:0] jump_reg_addr;
  logic [XLEN-1:0] jump_addr;
  // instruction memory request/response
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_resp_valid;
  logic [XLEN-1:0] imem_resp_data;
  // decode-side handshake
  logic            instr_valid;
  logic            instr_ready;
  logic [XLEN-1:0] instr;
  logic [XLEN-1:0] pc_plus_4;

  // fetch unit side
  modport master (
    input  jump, jump_reg, branch, branch_addr, jump_reg_addr, jump_addr,
    input  imem_req_ready, imem_resp_valid, imem_resp_data, instr_ready,
    output imem_req_valid, imem_req_addr, instr_valid, instr, pc_plus_4
  );

  // environment side (PC select, memory, decode)
  modport slave (
    output jump, jump_reg, branch, branch_addr, jump_reg_addr, jump_addr,
    output imem_req_ready, imem_resp_valid, imem_resp_data, instr_ready,
    input  imem_req_valid, imem_req_addr, instr_valid, instr, pc_plus_4
  );
endinterface

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO with wrap-around pointers, flush and occupancy.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic [W-1:0]               data_i,
  input  logic                       pop_i,
  output logic [W-1:0]               data_o,
  output logic [$clog2(DEPTH):0]     count_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  // Pointer/occupancy next state; DEPTH is a power of two so pointers wrap.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop_i)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  // Pointer/occupancy registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write; contents need no reset since occupancy qualifies the head.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/fetch_queue.sv
// Decoupled fetch unit: own PC, credit-limited imem requests, prefetch queue,
// and redirect squashing of queued and in-flight fetches.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEFAULT,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
  input  logic          clk,
  input  logic          rst_n,
  fetch_queue_if.master bus
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0]   resp_pc_q, resp_pc_d;     // address of next kept response
  logic [CW-1:0]     outstanding_q, outstanding_d;
  logic [CW-1:0]     drop_cnt_q, drop_cnt_d;
  logic [CW-1:0]     count;
  logic [CW:0]       credit_used;
  logic              redirect;
  logic [XLEN-1:0]   target;
  logic              req_fire, resp_fire, resp_drop, enq, deq;
  logic [2*XLEN-1:0] head;

  assign redirect = bus.branch | bus.jump;
  assign target   = select_target(bus.branch, bus.jump_reg, bus.branch_addr,
                                  bus.jump_reg_addr, bus.jump_addr);

  // Queued plus in-flight entries may never exceed DEPTH, so every response
  // has a queue slot waiting for it.
  assign credit_used        = {1'b0, count} + {1'b0, outstanding_q};
  assign bus.imem_req_valid = rst_n & (credit_used < (CW+1)'(DEPTH));
  assign bus.imem_req_addr  = {fetch_pc_q[XLEN-1:2], 2'b00};

  assign req_fire  = bus.imem_req_valid & bus.imem_req_ready;
  assign resp_fire = bus.imem_resp_valid;
  assign resp_drop = (drop_cnt_q != '0);
  assign enq       = resp_fire & ~resp_drop & ~redirect;
  assign deq       = bus.instr_valid & bus.instr_ready;

  // Next-state for PC, response address tracker and request counters.
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    outstanding_d = outstanding_q;
    drop_cnt_d    = drop_cnt_q;
    if (req_fire) fetch_pc_d = fetch_pc_q + XLEN'(4);
    if (enq)      resp_pc_d  = resp_pc_q + XLEN'(4);
    case ({req_fire, resp_fire})
      2'b10:   outstanding_d = outstanding_q + CW'(1);
      2'b01:   outstanding_d = outstanding_q - CW'(1);
      default: outstanding_d = outstanding_q;
    endcase
    if (resp_fire && resp_drop) drop_cnt_d = drop_cnt_q - CW'(1);
    if (redirect) begin
      // Everything still in flight after this edge belongs to the old path.
      fetch_pc_d = target;
      resp_pc_d  = {target[XLEN-1:2], 2'b00};
      drop_cnt_d = outstanding_d;
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= {RESET_PC[XLEN-1:2], 2'b00};
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .W     (2*XLEN)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (redirect),
    .push_i  (enq),
    .data_i  ({bus.imem_resp_data, resp_pc_q + XLEN'(4)}),
    .pop_i   (deq),
    .data_o  (head),
    .count_o (count)
  );

  assign bus.instr_valid = (count != '0);
  assign bus.instr       = bus.instr_valid ? head[2*XLEN-1:XLEN] : XLEN'(NOP_INSTR);
  assign bus.pc_plus_4   = bus.instr_valid ? head[XLEN-1:0] : '0;

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: queue-level reference model plus an
// in-order latency memory model, directed scenarios and a random soak.
module tb_fetch_queue;
  localparam int          DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h0040_0020;

  typedef struct { logic [31:0] instr; logic [31:0] pc4; } entry_t;
  typedef struct { logic [31:0] addr;  bit stale; }        flight_t;
  typedef struct { logic [31:0] addr;  int rdy; }          pend_t;

  logic clk = 0;
  logic rst_n;
  always #5 clk = ~clk;

  fetch_queue_if #(.XLEN(32)) bus ();

  fetch_queue #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // reference model state
  entry_t      mq[$];
  flight_t     mfl[$];
  pend_t       mem[$];
  entry_t      deq_log[$];
  logic [31:0] mpc;
  int          cyc = 0;
  int          n_cmp = 0, n_fail = 0;
  int          req_cnt = 0, deq_cnt = 0, drop_cnt = 0;

  // stimulus controls
  int          ready_mode = 1, resp_mode = 0, ir_mode = 1, lat = 1;
  logic        g_branch = 0, g_jump = 0, g_jump_reg = 0;
  logic [31:0] g_baddr = 0, g_jraddr = 0, g_jaddr = 0;

  function automatic logic [31:0] memdata(logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  task automatic cmp(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete(); mfl.delete(); mem.delete();
    mpc = RPC;
  endtask

  task automatic check_outputs();
    logic        ev;
    logic [31:0] ei, ep;
    ev = (mq.size() > 0);
    ei = ev ? mq[0].instr : 32'h0;
    ep = ev ? mq[0].pc4   : 32'h0;
    cmp("imem_req_valid", {31'b0, bus.imem_req_valid},
        {31'b0, (rst_n === 1'b1) && (mq.size() + mfl.size() < DEPTH)});
    cmp("imem_req_addr", bus.imem_req_addr, {mpc[31:2], 2'b00});
    cmp("instr_valid", {31'b0, bus.instr_valid}, {31'b0, ev});
    cmp("instr", bus.instr, ei);
    cmp("pc_plus_4", bus.pc_plus_4, ep);
  endtask

  // Apply one clock edge to the model using the inputs driven this cycle.
  task automatic model_update();
    bit          rv, rf, redir;
    logic [31:0] tgt;
    flight_t     f;
    if (!rst_n) begin
      model_reset();
      return;
    end
    rv    = (mq.size() + mfl.size() < DEPTH);
    rf    = rv && bus.imem_req_ready;
    redir = bus.branch || bus.jump;
    tgt   = bus.branch ? bus.branch_addr : (bus.jump_reg ? bus.jump_reg_addr : bus.jump_addr);
    if (mq.size() > 0 && bus.instr_ready) begin
      deq_log.push_back(mq.pop_front());
      deq_cnt++;
    end
    if (bus.imem_resp_valid) begin
      f = mfl.pop_front();
      void'(mem.pop_front());
      if (!f.stale && !redir) mq.push_back('{memdata(f.addr), f.addr + 32'd4});
      else drop_cnt++;
    end
    if (rf) begin
      mfl.push_back('{{mpc[31:2], 2'b00}, 1'b0});
      mem.push_back('{{mpc[31:2], 2'b00}, cyc + lat});
      mpc = mpc + 32'd4;
      req_cnt++;
    end
    if (redir) begin
      mq.delete();
      foreach (mfl[i]) mfl[i].stale = 1'b1;
      mpc = tgt;
    end
  endtask

  task automatic step();
    @(negedge clk);
    check_outputs();
    bus.imem_req_ready = (ready_mode == 2) ? ($urandom_range(0, 99) < 70) : ready_mode[0];
    bus.instr_ready    = (ir_mode == 2)    ? ($urandom_range(0, 99) < 70) : ir_mode[0];
    if (rst_n && mem.size() > 0 && cyc >= mem[0].rdy &&
        (resp_mode == 0 || $urandom_range(0, 99) < 70)) begin
      bus.imem_resp_valid = 1'b1;
      bus.imem_resp_data  = memdata(mem[0].addr);
    end else begin
      bus.imem_resp_valid = 1'b0;
      bus.imem_resp_data  = $urandom;
    end
    bus.branch = g_branch; bus.jump = g_jump; bus.jump_reg = g_jump_reg;
    bus.branch_addr = g_baddr; bus.jump_reg_addr = g_jraddr; bus.jump_addr = g_jaddr;
    @(posedge clk);
    model_update();
    cyc++;
    g_branch = 0; g_jump = 0; g_jump_reg = 0;
    #1;
  endtask

  task automatic do_reset(int n);
    rst_n = 0;
    repeat (n) step();
    rst_n = 1;
  endtask

  initial begin
    int d0, r0;
    rst_n = 0;
    bus.imem_req_ready = 0; bus.instr_ready = 0; bus.imem_resp_valid = 0;
    bus.imem_resp_data = 0; bus.branch = 0; bus.jump = 0; bus.jump_reg = 0;
    bus.branch_addr = 0; bus.jump_reg_addr = 0; bus.jump_addr = 0;
    repeat (2) @(posedge clk);
    model_reset();
    #1;

    // reset values, then straight-line fetch with a 1-cycle memory
    do_reset(3);
    cmp("reset_addr", bus.imem_req_addr, 32'h0040_0020);
    cmp("reset_ivalid", {31'b0, bus.instr_valid}, 32'h0);
    deq_log.delete();
    repeat (8) step();
    cmp("seq0_pc4", deq_log[0].pc4, 32'h0040_0024);
    cmp("seq1_pc4", deq_log[1].pc4, 32'h0040_0028);
    cmp("seq2_pc4", deq_log[2].pc4, 32'h0040_002C);
    cmp("seq0_instr", deq_log[0].instr, memdata(32'h0040_0020));

    // decode stall: exactly DEPTH requests, then held
    do_reset(2);
    ir_mode = 0;
    r0 = req_cnt;
    repeat (20) step();
    cmp("stall_reqs", req_cnt - r0, 32'd4);
    cmp("stall_reqvalid", {31'b0, bus.imem_req_valid}, 32'h0);
    cmp("stall_head", bus.pc_plus_4, 32'h0040_0024);
    ir_mode = 1;
    d0 = deq_cnt;
    repeat (4) step();
    cmp("release_deqs", deq_cnt - d0, 32'd4);

    // 3-cycle memory, branch with requests in flight
    lat = 3;
    do_reset(2);
    for (int k = 0; k < 10 && mfl.size() < 2; k++) step();
    d0 = drop_cnt;
    g_branch = 1; g_baddr = 32'h0040_0100;
    step();
    cmp("br_addr", bus.imem_req_addr, 32'h0040_0100);
    cmp("br_ivalid", {31'b0, bus.instr_valid}, 32'h0);
    for (int k = 0; k < 30 && mq.size() == 0; k++) step();
    cmp("br_drops_ge2", {31'b0, (drop_cnt - d0) >= 2}, 32'h1);
    cmp("br_model_pc4", mq.size() > 0 ? mq[0].pc4 : 32'hDEAD_BEEF, 32'h0040_0104);
    cmp("br_dut_pc4", bus.pc_plus_4, 32'h0040_0104);
    cmp("br_dut_instr", bus.instr, memdata(32'h0040_0100));

    // target priority with requests held off
    lat = 1; ready_mode = 0;
    repeat (6) step();
    g_branch = 1; g_jump = 1; g_baddr = 32'h200; g_jaddr = 32'h300;
    step();
    cmp("prio_branch", bus.imem_req_addr, 32'h0000_0200);
    g_jump = 1; g_jump_reg = 1; g_jraddr = 32'h404; g_jaddr = 32'h300;
    step();
    cmp("prio_jreg", bus.imem_req_addr, 32'h0000_0404);
    g_jump_reg = 1; g_jraddr = 32'h800;
    step();
    cmp("jreg_alone", bus.imem_req_addr, 32'h0000_0404);

    // redirect coinciding with a response and a request handshake
    ready_mode = 1;
    repeat (6) step();
    d0 = drop_cnt;
    g_jump = 1; g_jaddr = 32'h0000_1000;
    step();
    cmp("co_addr", bus.imem_req_addr, 32'h0000_1000);
    for (int k = 0; k < 20 && mq.size() == 0; k++) step();
    cmp("co_drops", drop_cnt - d0, 32'd2);
    cmp("co_pc4", bus.pc_plus_4, 32'h0000_1004);

    // address wrap
    ready_mode = 0;
    repeat (6) step();
    g_jump = 1; g_jaddr = 32'hFFFF_FFFC;
    step();
    cmp("wrap_pre", bus.imem_req_addr, 32'hFFFF_FFFC);
    ready_mode = 1;
    step();
    cmp("wrap_post", bus.imem_req_addr, 32'h0000_0000);

    // mid-stream reset
    ir_mode = 0;
    repeat (5) step();
    rst_n = 0;
    step();
    cmp("mrst_reqvalid", {31'b0, bus.imem_req_valid}, 32'h0);
    cmp("mrst_addr", bus.imem_req_addr, 32'h0040_0020);
    cmp("mrst_ivalid", {31'b0, bus.instr_valid}, 32'h0);
    cmp("mrst_instr", bus.instr, 32'h0);
    cmp("mrst_pc4", bus.pc_plus_4, 32'h0);
    rst_n = 1;

    // random soak
    ready_mode = 2; resp_mode = 1; ir_mode = 2;
    for (int n = 0; n < 3000; n++) begin
      lat = $urandom_range(1, 4);
      if ($urandom_range(0, 99) < 6) begin
        g_branch   = $urandom_range(0, 1);
        g_jump     = ~g_branch | ($urandom_range(0, 1) == 1);
        g_jump_reg = $urandom_range(0, 1);
        g_baddr = $urandom; g_jraddr = $urandom; g_jaddr = $urandom;
      end else if ($urandom_range(0, 99) < 3) begin
        g_jump_reg = 1; g_jraddr = $urandom;
      end
      rst_n = ($urandom_range(0, 999) < 3) ? 1'b0 : 1'b1;
      step();
    end
    rst_n = 1;
    repeat (3) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Parametrised successor to the single-register fetch stage: a decoupled instruction fetch unit with its own PC, a latency-tolerant instruction-memory request/response port, and a DEPTH-entry prefetch queue feeding the decode register. Redirects (branch, j/jal, jr) squash queued and in-flight fetches. Decode-side stall becomes a valid/ready handshake instead of a bare enable. Sits between the PC-select logic and the decode pipeline register.

## Interface
- XLEN, 32, instruction/address width
- DEPTH, 4, prefetch queue entries; power of two, ≥2; also the maximum number of outstanding imem requests
- RESET_PC, 32'h00400020, first fetch address after reset
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  synchronous active-low reset
- jump  in  1  j/jal/jr redirect request
- jump_reg  in  1  with jump: target is jump_reg_addr, otherwise jump_addr
- branch  in  1  taken-branch redirect; wins over jump
- branch_addr, jump_reg_addr, jump_addr  in  XLEN each  redirect targets
- imem_req_valid  out  1  fetch request
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  XLEN  word-aligned fetch address
- imem_resp_valid  in  1  in-order response strobe
- imem_resp_data  in  XLEN  instruction word
- instr_valid  out  1  queue head valid
- instr_ready  in  1  decode accepts head (replaces enable / not stallF)
- instr  out  XLEN  head instruction
- pc_plus_4  out  XLEN  head address + 4

## Operation
- redirect = branch | jump; target = branch ? branch_addr : (jump_reg ? jump_reg_addr : jump_addr); jump_reg ignored when jump=0.
- fetch_pc register; imem_req_addr = {fetch_pc[XLEN-1:2], 2'b00}. On req handshake fetch_pc += 4, modulo 2^XLEN.
- Credit rule: imem_req_valid = rst_n & (count + outstanding < DEPTH); not gated by redirect.
- outstanding: +1 per request handshake, −1 per response; both in one cycle → unchanged.
- Response with drop_cnt>0: discarded, drop_cnt−1. Else enqueue {data, req_addr+4}; credit rule guarantees no overflow.
- Dequeue on instr_valid & instr_ready.
- Redirect cycle: queue cleared; fetch_pc ← target (any same-cycle handshake increment overridden); drop_cnt ← outstanding value after this cycle's updates, so any same-cycle request is dropped and any same-cycle response is discarded. Same-cycle dequeue is still valid (decode took it).
- Empty queue: instr = 0 (nop), pc_plus_4 = 0, instr_valid = 0.
- Counters count/outstanding/drop_cnt: $clog2(DEPTH)+1 bits; drop_cnt ≤ outstanding ≤ DEPTH always.

## Timing
- Reset (rst_n low at edge): fetch_pc=RESET_PC, count=outstanding=drop_cnt=0; outputs: imem_req_valid=0 (combinational on rst_n), imem_req_addr=RESET_PC, instr_valid=0, instr=0, pc_plus_4=0. Reset mid-operation discards everything; responses arriving afterwards for pre-reset requests are the memory's responsibility (memory shares rst_n).
- First request cycle after rst_n rises.
- Response-to-instr_valid latency: 1 cycle (registered enqueue); no combinational path imem_resp → instr.
- Redirect at edge t: instr_valid=0 from t+1, imem_req_addr=target from t+1; first redirected instr visible ≥ t+1+memory latency+1.
- Full queue with instr_ready=0: imem_req_valid=0; holds indefinitely, head stable.
- Back-to-back throughput: 1 instr/cycle with zero-wait memory and DEPTH≥2.

## Structure
- fetch_pkg: XLEN default, RESET_PC, NOP_INSTR (32'h0), redirect-target select function.
- One sub-module: fetch_fifo (sync FIFO, DEPTH×2·XLEN, wrap-around pointers, flush input, count output).

## Test plan
- Reset → imem_req_addr=32'h00400020, instr_valid=0; release with 1-cycle memory → instrs at 0x00400020/24/28 with pc_plus_4 0x00400024/28/2C.
- instr_ready=0 for 20 cycles, DEPTH=4 → exactly 4 requests issued, imem_req_valid stays 0, head unchanged; release → 4 dequeues in 4 cycles.
- 3-cycle memory, 2 outstanding, branch=1 branch_addr=0x00400100 → both stale responses discarded, next instr_valid shows imem 0x00400100, pc_plus_4=0x00400104.
- branch=1 and jump=1 same cycle (branch_addr=0x200, jump_addr=0x300) → fetch 0x200; jump=1 jump_reg=1 jump_reg_addr=0x404 → fetch 0x404; jump_reg=1 alone → no redirect.
- Redirect coinciding with response and request handshake → that response dropped, dropped request's response also discarded; fetch_pc=target.
- fetch_pc=0xFFFFFFFC → next request addr 0x00000000; rst_n low mid-stream → all outputs at reset values next cycle.
